apb_cmd_master: RTL and testbench
=================================

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 16, APB/command address width.
- DATA_W, 32, data width; multiple of 8.
- FIFO_DEPTH, 4, command FIFO entries; power of two, >=2.
- TIMEOUT_CYC, 255, maximum ACCESS wait cycles; >=1.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- pclk, in, 1, sole clock; all logic on its rising edge.
- presetn, in, 1, asynchronous active-low reset.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, command FIFO not full.
- cmd_write, in, 1, 1 = write, 0 = read.
- cmd_addr, in, ADDR_W, transfer address.
- cmd_wdata, in, DATA_W, write data.
- cmd_strb, in, DATA_W/8, write byte strobes.
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, response consumed.
- rsp_rdata, out, DATA_W, read data; 0 for writes and errors.
- rsp_err, out, 1, pslverr or timeout.
- paddr, out, ADDR_W, APB address.
- psel, out, 1, APB select.
- penable, out, 1, APB enable.
- pwrite, out, 1, APB direction.
- pwdata, out, DATA_W, APB write data.
- pstrb, out, DATA_W/8, APB4 strobes.
- pready, in, 1, APB ready.
- prdata, in, DATA_W, APB read data.
- pslverr, in, 1, APB slave error.
- busy, out, 1, FIFO non-empty or state != IDLE.

Function
REQ-003 A command SHALL be pushed into the FIFO on each rising edge with cmd_valid && cmd_ready; cmd_ready SHALL equal !full, derived from a registered count.
REQ-004 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP.
REQ-005 IDLE -> SETUP SHALL occur when the FIFO is non-empty; the head entry SHALL be popped and latched into the transfer registers on that edge.
REQ-006 In SETUP, outputs SHALL be psel=1 and penable=0; the FSM SHALL move unconditionally to ACCESS (psel=1, penable=1) on the next edge.
REQ-007 In ACCESS with pready=1, the FSM SHALL go to RESP, deassert psel and penable, and register rsp_valid=1, rsp_err=pslverr and rsp_rdata (prdata for an error-free read, else 0).
REQ-008 In RESP, rsp_valid SHALL hold with stable data until rsp_ready=1; on that edge the FSM SHALL go to SETUP (popping the next entry) if the FIFO is non-empty, else to IDLE.
REQ-009 paddr, pwrite, pwdata and pstrb SHALL be stable from SETUP through ACCESS; for reads, pwdata=0 and pstrb=0.
REQ-010 With an idle FSM, psel SHALL rise on the 2nd rising edge after the command handshake; the minimum command-to-rsp_valid latency is 4 edges (pready=1 in the first ACCESS cycle).
REQ-011 A push and a pop on the same edge SHALL leave the count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-012 Commands SHALL complete strictly in acceptance order, with one outstanding APB transfer at a time.

Reset
REQ-013 Asserting presetn low SHALL asynchronously force state IDLE, empty the FIFO, and drive psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err and busy to 0, with cmd_ready=0 while reset is asserted.
REQ-014 Reset during an APB transfer SHALL abort it with no response; deassertion SHALL be synchronised to pclk, and cmd_ready SHALL be 1 on the first edge after release.

Configuration
REQ-015 With macro APB_CMD_MASTER_TIMEOUT_EN defined, a counter SHALL clear on SETUP and increment each ACCESS cycle with pready=0.
- When it reaches TIMEOUT_CYC, the FSM SHALL go to RESP with rsp_err=1, rsp_rdata=0, and psel/penable deasserted.
- Without the macro, there SHALL be no counter, and ACCESS SHALL wait indefinitely for pready.

Verification
REQ-016 Write addr=0x0010, data=0xA5A5_5A5A, strb=0xF, pready=1 -> one SETUP cycle and one ACCESS cycle with matching paddr/pwdata/pstrb; rsp_valid=1, rsp_err=0, rsp_rdata=0.
REQ-017 Read addr=0x0020, pready low for 3 ACCESS cycles, prdata=0x1234_5678 -> penable high for 4 cycles; rsp_rdata=0x1234_5678, pstrb=0.
REQ-018 Push 5 commands with rsp_ready=1 and pready=0 (FIFO_DEPTH=4) -> after the first pop, 4 entries are buffered and cmd_ready=0; once transfers drain, all 5 responses arrive in order.
REQ-019 Read with pslverr=1 on the completing cycle -> rsp_err=1, rsp_rdata=0; the next queued command proceeds normally.
REQ-020 With APB_CMD_MASTER_TIMEOUT_EN defined and TIMEOUT_CYC=8, pready held 0 -> after 8 ACCESS cycles psel drops and rsp_err=1; without the macro, psel stays high.
REQ-021 presetn low mid-ACCESS with 2 entries queued -> psel=0 and rsp_valid=0 immediately; FIFO empty and no responses after release.

Source files
------------

// File: rtl/apb_cmd_master.sv
// APB4 command master: queues commands in a small FIFO and issues them as single APB transfers in order.
// Optional ACCESS-phase timeout is enabled by defining APB_CMD_MASTER_TIMEOUT_EN.

module apb_cmd_master #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   paddr,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic                pready,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pslverr,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W  = 1 + ADDR_W + DATA_W + STRB_W;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rst_sync;
    logic [ENT_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_complete;
    logic                w_timeout;
    logic                w_rsp_take;
    logic                w_tmo_hit;
    logic [ENT_W-1:0]    w_head;
    logic                w_head_write;
    logic [ADDR_W-1:0]   w_head_addr;
    logic [DATA_W-1:0]   w_head_wdata;
    logic [STRB_W-1:0]   w_head_strb;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic [STRB_W-1:0]   r_pstrb;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_rsp_rdata;

    // Command intake stays closed until the first edge after reset release,
    // which keeps the whole block quiet until deassertion is seen by pclk.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) r_rst_sync <= 1'b0;
        else          r_rst_sync <= 1'b1;
    end

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign cmd_ready = r_rst_sync & ~w_full;
    assign w_push    = cmd_valid & cmd_ready;

    always_ff @(posedge pclk) begin
        if (w_push) r_mem[r_wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata, cmd_strb};
    end

    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_write = w_head[ENT_W-1];
    assign w_head_addr  = w_head[ENT_W-2 -: ADDR_W];
    assign w_head_wdata = w_head[STRB_W +: DATA_W];
    assign w_head_strb  = w_head[STRB_W-1:0];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // The last stalled ACCESS cycle is the one where the count is one short.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)                            r_tmo_cnt <= '0;
        else if (r_state == SETUP)               r_tmo_cnt <= '0;
        else if (r_state == ACCESS && !pready)   r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end

    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYC > 0);
    assign w_tmo_hit    = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        w_rsp_take  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = SETUP;
                    w_pop       = 1'b1;
                end
            end
            SETUP: w_state_nxt = ACCESS;
            ACCESS: begin
                if (pready) begin
                    w_state_nxt = RESP;
                    w_complete  = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_nxt = RESP;
                    w_timeout   = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_take  = 1'b1;
                    w_pop       = ~w_empty;
                    w_state_nxt = w_empty ? IDLE : SETUP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Reads carry no write payload onto the bus.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
        end else if (w_pop) begin
            r_pwrite <= w_head_write;
            r_paddr  <= w_head_addr;
            r_pwdata <= w_head_write ? w_head_wdata : '0;
            r_pstrb  <= w_head_write ? w_head_strb  : '0;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else if (w_complete) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= pslverr;
            r_rsp_rdata <= (!r_pwrite && !pslverr) ? prdata : '0;
        end else if (w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
        end else if (w_rsp_take) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign psel      = (r_state == SETUP) || (r_state == ACCESS);
    assign penable   = (r_state == ACCESS);
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign pstrb     = r_pstrb;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = ~w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: transaction-level model plus directed scenarios.
// Honours APB_CMD_MASTER_TIMEOUT_EN to select the expected stall behaviour.

module tb_apb_cmd_master;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int DEPTH  = 4;
    localparam int TMO    = 8;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } cmd_t;

    logic              pclk = 1'b0;
    logic              presetn;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] paddr;
    logic              psel, penable, pwrite, pready, pslverr, busy;
    logic [DATA_W-1:0] pwdata, prdata;
    logic [STRB_W-1:0] pstrb;

    logic              autoRdata, errEn;
    logic [DATA_W-1:0] fixedRdata;
    logic [ADDR_W-1:0] errAddr;
    logic              outOfReset;

    int                checks = 0;
    int                failures = 0;

    cmd_t              pendq[$];
    cmd_t              cur;
    bit                curActive, rspExpValid, mustSetup, prevSetup;
    logic [DATA_W-1:0] rspExpData;
    logic              rspExpErr;
    int                accWait;
    logic [DATA_W-1:0] rspLogData[$];
    logic              rspLogErr[$];

    always #5 pclk = ~pclk;

    // Simple APB slave: read data derived from the address unless pinned.
    assign prdata  = autoRdata ? {~paddr, paddr} : fixedRdata;
    assign pslverr = errEn && (paddr == errAddr);

    apb_cmd_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
        .pslverr(pslverr), .busy(busy)
    );

    // Intake may open only from the first edge seen after reset release.
    always @(posedge pclk or negedge presetn) begin
        if (!presetn) outOfReset <= 1'b0;
        else          outOfReset <= 1'b1;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model process: outputs checked against the transaction model at every negedge,
    // then the model absorbs what the coming rising edge will commit.
    initial begin
        bit sawSetup;
        cmd_t c;
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                checkOutput("rst_ctrl", {psel, penable, pwrite, rsp_valid, rsp_err, busy, cmd_ready}, 7'b0);
                checkOutput("rst_paddr", paddr, 0);
                checkOutput("rst_pwdata", pwdata, 0);
                checkOutput("rst_pstrb", pstrb, 0);
                checkOutput("rst_rdata", rsp_rdata, 0);
                pendq.delete();
                curActive = 0; rspExpValid = 0; mustSetup = 0; prevSetup = 0; accWait = 0;
            end else begin
                sawSetup = psel && !penable;
                if (mustSetup) checkOutput("setup_start", sawSetup, 1);
                if (prevSetup) checkOutput("setup_to_access", {psel, penable}, 2'b11);
                if (sawSetup) begin
                    checkOutput("setup_legal", {curActive, pendq.size() == 0}, 2'b00);
                    if (!curActive && pendq.size() > 0) begin
                        cur = pendq.pop_front();
                        curActive = 1;
                        accWait = 0;
                    end
                end
                checkOutput("psel_owner", psel && !curActive, 0);
                if (psel && curActive) begin
                    checkOutput("paddr", paddr, cur.addr);
                    checkOutput("pwrite", pwrite, cur.write);
                    checkOutput("pwdata", pwdata, cur.write ? cur.wdata : '0);
                    checkOutput("pstrb", pstrb, cur.write ? cur.strb : '0);
                end
                checkOutput("cmd_ready", cmd_ready, outOfReset && (pendq.size() < DEPTH));
                checkOutput("busy", busy, (pendq.size() > 0) || curActive);
                checkOutput("rsp_valid", rsp_valid, rspExpValid);
                if (rsp_valid && rspExpValid) begin
                    checkOutput("rsp_rdata", rsp_rdata, rspExpData);
                    checkOutput("rsp_err", rsp_err, rspExpErr);
                end

                mustSetup = !curActive && (pendq.size() > 0);
                if (psel && penable && pready && curActive) begin
                    rspExpValid = 1;
                    rspExpErr   = pslverr;
                    rspExpData  = (!cur.write && !pslverr) ? prdata : '0;
                end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                else if (psel && penable && !pready && curActive) begin
                    accWait++;
                    if (accWait == TMO) begin
                        rspExpValid = 1;
                        rspExpErr   = 1;
                        rspExpData  = '0;
                    end
                end
`endif
                if (rsp_valid && rsp_ready && rspExpValid) begin
                    rspLogData.push_back(rsp_rdata);
                    rspLogErr.push_back(rsp_err);
                    rspExpValid = 0;
                    curActive   = 0;
                    mustSetup   = pendq.size() > 0;
                end
                if (cmd_valid && cmd_ready) begin
                    c.write = cmd_write; c.addr = cmd_addr; c.wdata = cmd_wdata; c.strb = cmd_strb;
                    pendq.push_back(c);
                end
                prevSetup = sawSetup;
            end
        end
    end

    // Offer one command from posedge+1 and return at posedge+1 after the handshake.
    task automatic applyStimulus(input logic w, input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
        bit got = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge pclk);
            got = cmd_ready;
        end
        checkOutput("push_accept", got, 1);
        @(posedge pclk); #1;
        cmd_valid = 0;
    endtask

    task automatic waitRsp(input string name, input int target, input int budget);
        int n = 0;
        while (rspLogData.size() < target && n < budget) begin
            @(negedge pclk);
            n++;
        end
        checkOutput(name, rspLogData.size(), target);
        @(posedge pclk); #1;
    endtask

    task automatic waitAccess(input string name);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge pclk);
            seen = psel && penable;
        end
        checkOutput(name, seen, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        int accCnt;
        presetn = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_strb = 0;
        rsp_ready = 0; pready = 0; autoRdata = 1; fixedRdata = 0; errEn = 0; errAddr = 0;
        #1 presetn = 0;
        repeat (3) @(posedge pclk);
        #1 presetn = 1;
        @(negedge pclk); checkOutput("rel_ready_low", cmd_ready, 0);
        @(posedge pclk); #1;
        @(negedge pclk); checkOutput("rel_ready_high", cmd_ready, 1);
        @(posedge pclk); #1;

        // Single write, zero-wait slave: minimum latency path.
        $display("[TB] write with immediate pready");
        pready = 1; rsp_ready = 1;
        applyStimulus(1'b1, 16'h0010, 32'hA5A5_5A5A, 4'hF);
        @(negedge pclk);
        checkOutput("t1_wait", {psel, penable}, 2'b00);
        checkOutput("t1_busy", busy, 1);
        @(negedge pclk);
        checkOutput("t1_setup", {psel, penable}, 2'b10);
        checkOutput("t1_paddr", paddr, 16'h0010);
        checkOutput("t1_pwdata", pwdata, 32'hA5A5_5A5A);
        checkOutput("t1_pstrb", pstrb, 4'hF);
        checkOutput("t1_pwrite", pwrite, 1);
        @(negedge pclk);
        checkOutput("t1_access", {psel, penable}, 2'b11);
        checkOutput("t1_paddr_acc", paddr, 16'h0010);
        @(negedge pclk);
        checkOutput("t1_rsp", {rsp_valid, rsp_err, psel, penable}, 4'b1000);
        checkOutput("t1_rdata", rsp_rdata, 0);
        @(negedge pclk);
        checkOutput("t1_idle", {rsp_valid, busy}, 2'b00);
        @(posedge pclk); #1;

        // Read with three wait states and a held response.
        $display("[TB] read with wait states");
        pready = 0; rsp_ready = 0; autoRdata = 0; fixedRdata = 32'h1234_5678;
        applyStimulus(1'b0, 16'h0020, 32'hDEAD_BEEF, 4'hF);
        @(negedge pclk);
        checkOutput("t2_wait", psel, 0);
        @(negedge pclk);
        checkOutput("t2_setup", {psel, penable, pwrite}, 3'b100);
        checkOutput("t2_pstrb", pstrb, 0);
        checkOutput("t2_pwdata", pwdata, 0);
        checkOutput("t2_paddr", paddr, 16'h0020);
        accCnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            if (psel && penable) accCnt++;
        end
        checkOutput("t2_stall_cycles", accCnt, 3);
        @(posedge pclk); #1 pready = 1;
        @(negedge pclk);
        checkOutput("t2_access4", {psel, penable}, 2'b11);
        checkOutput("t2_pstrb_acc", pstrb, 0);
        @(negedge pclk);
        checkOutput("t2_rsp", {rsp_valid, rsp_err, psel}, 3'b100);
        checkOutput("t2_rdata", rsp_rdata, 32'h1234_5678);
        @(negedge pclk);
        checkOutput("t2_hold", {rsp_valid, rsp_err}, 2'b10);
        checkOutput("t2_hold_data", rsp_rdata, 32'h1234_5678);
        @(posedge pclk); #1 rsp_ready = 1;
        @(negedge pclk);
        @(posedge pclk); #1;
        @(negedge pclk);
        checkOutput("t2_drained", {rsp_valid, busy}, 2'b00);
        @(posedge pclk); #1;

        // Five commands against a stalled slave: FIFO fills, then drains in order.
        $display("[TB] fifo fill and ordered drain");
        pready = 0; rsp_ready = 1; autoRdata = 1;
        start = rspLogData.size();
        applyStimulus(1'b1, 16'h0100, 32'h1111_1111, 4'hF);
        applyStimulus(1'b0, 16'h0104, 32'h0, 4'h0);
        applyStimulus(1'b1, 16'h0108, 32'h3333_3333, 4'h5);
        applyStimulus(1'b0, 16'h010C, 32'h0, 4'h0);
        applyStimulus(1'b0, 16'h0110, 32'h0, 4'h0);
        @(negedge pclk);
        checkOutput("t3_full", cmd_ready, 0);
        checkOutput("t3_first_stuck", {psel, penable}, 2'b11);
        checkOutput("t3_first_addr", paddr, 16'h0100);
        @(posedge pclk); #1 pready = 1;
        waitRsp("t3_count", start + 5, 200);
        checkOutput("t3_r0", rspLogData[start], 32'h0);
        checkOutput("t3_r1", rspLogData[start+1], 32'hFEFB_0104);
        checkOutput("t3_r3", rspLogData[start+3], 32'hFEF3_010C);
        checkOutput("t3_r4", rspLogData[start+4], 32'hFEEF_0110);

        // Slave error on a read, followed by a clean read.
        $display("[TB] slave error then normal read");
        errEn = 1; errAddr = 16'h0200;
        start = rspLogData.size();
        applyStimulus(1'b0, 16'h0200, 32'h0, 4'h0);
        applyStimulus(1'b0, 16'h0204, 32'h0, 4'h0);
        waitRsp("t4_count", start + 2, 100);
        checkOutput("t4_err0", rspLogErr[start], 1);
        checkOutput("t4_data0", rspLogData[start], 32'h0);
        checkOutput("t4_err1", rspLogErr[start+1], 0);
        checkOutput("t4_data1", rspLogData[start+1], 32'hFDFB_0204);
        errEn = 0;

        // Slave never ready.
        $display("[TB] stalled slave");
        pready = 0;
        start = rspLogData.size();
        applyStimulus(1'b1, 16'h0300, 32'h0BAD_F00D, 4'h3);
        waitAccess("t5_access");
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        accCnt = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge pclk);
            if (psel && penable) accCnt++;
            else break;
        end
        checkOutput("t5_tmo_cycles", accCnt, TMO);
        checkOutput("t5_tmo_rsp", {psel, rsp_valid, rsp_err}, 3'b011);
        checkOutput("t5_tmo_rdata", rsp_rdata, 0);
        @(posedge pclk); #1 pready = 1;
        waitRsp("t5_count", start + 1, 20);
`else
        repeat (20) @(negedge pclk);
        checkOutput("t5_hold", {psel, penable, rsp_valid}, 3'b110);
        @(posedge pclk); #1 pready = 1;
        waitRsp("t5_count", start + 1, 20);
        checkOutput("t5_err", rspLogErr[start], 0);
`endif

        // Reset in the middle of a transfer with two entries queued.
        $display("[TB] reset during access");
        pready = 0; rsp_ready = 1;
        start = rspLogData.size();
        applyStimulus(1'b1, 16'h0400, 32'hCAFE_0001, 4'hF);
        applyStimulus(1'b0, 16'h0404, 32'h0, 4'h0);
        applyStimulus(1'b1, 16'h0408, 32'hCAFE_0003, 4'hF);
        @(negedge pclk);
        checkOutput("t6_in_access", {psel, penable, busy}, 3'b111);
        @(posedge pclk); #1 presetn = 0;
        #1;
        checkOutput("t6_abort", {psel, penable, rsp_valid, busy, cmd_ready}, 5'b0);
        @(posedge pclk);
        @(posedge pclk); #1 presetn = 1; pready = 1;
        @(negedge pclk);
        checkOutput("t6_ready_low", cmd_ready, 0);
        repeat (10) @(negedge pclk);
        checkOutput("t6_no_rsp", rspLogData.size(), start);
        checkOutput("t6_idle", {busy, psel, rsp_valid, cmd_ready}, 4'b0001);
        @(posedge pclk); #1;

        // Normal service resumes after reset.
        applyStimulus(1'b0, 16'h0500, 32'h0, 4'h0);
        waitRsp("t7_count", start + 1, 20);
        checkOutput("t7_data", rspLogData[start], 32'hFAFF_0500);

        repeat (3) @(posedge pclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
